// File: rtl/fft4_stream.sv
// fft4_stream: streaming 4-point radix-4 FFT/IFFT.
//
// Complex samples come in one at a time on a valid/ready input. Four bins per frame go out in
// natural order on a valid/ready output. The design is double-buffered, so frame N+1 is collected
// while frame N drains.
//
// Parameters
//   DATA_WIDTH  input width per real/imag part, signed
//   SCALE       0: full-precision bins; 1: each bin part arithmetic-shifted right by 2 (floor /4)
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous reset, active-high
//   s_valid_i    input sample valid
//   s_ready_o    input can accept a sample
//   s_real_i     input sample real part, signed
//   s_imag_i     input sample imag part, signed
//   s_inv_i      1 = inverse transform; sampled only with the first sample of a frame
//   m_valid_o    output bin valid
//   m_ready_i    downstream accepts the bin
//   m_real_o     output bin real part, signed, DATA_WIDTH+2 bits
//   m_imag_o     output bin imag part, signed, DATA_WIDTH+2 bits
//   m_last_o     high with bin 3, the last bin of a frame
module fft4_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SCALE      = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_real_i,
    input  logic [DATA_WIDTH-1:0] s_imag_i,
    input  logic                  s_inv_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH+1:0] m_real_o,
    output logic [DATA_WIDTH+1:0] m_imag_o,
    output logic                  m_last_o
);

    localparam int unsigned OW = DATA_WIDTH + 2;

    // Input side state
    logic [1:0]            in_cnt_q, in_cnt_d;
    logic                  full_in_q, full_in_d;
    logic                  frame_inv_q, frame_inv_d;
    logic [DATA_WIDTH-1:0] buf_re_q [4];
    logic [DATA_WIDTH-1:0] buf_re_d [4];
    logic [DATA_WIDTH-1:0] buf_im_q [4];
    logic [DATA_WIDTH-1:0] buf_im_d [4];

    // Output side state
    logic                  out_busy_q, out_busy_d;
    logic [1:0]            out_cnt_q, out_cnt_d;
    logic [OW-1:0]         bin_re_q [4];
    logic [OW-1:0]         bin_re_d [4];
    logic [OW-1:0]         bin_im_q [4];
    logic [OW-1:0]         bin_im_d [4];

    // Butterfly intermediates
    logic signed [OW-1:0]  x_re [4];
    logic signed [OW-1:0]  x_im [4];
    logic signed [OW-1:0]  f_re [4];
    logic signed [OW-1:0]  f_im [4];
    logic signed [OW-1:0]  a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;

    logic in_fire, out_fire, last_fire, xfer;

    assign s_ready_o = !full_in_q && !rst_i;
    assign in_fire   = s_valid_i && s_ready_o;
    assign out_fire  = out_busy_q && m_ready_i;
    assign last_fire = out_fire && (out_cnt_q == 2'd3);
    // A full input frame moves over when the output is idle or its last bin leaves this cycle.
    assign xfer      = full_in_q && (!out_busy_q || last_fire);

    assign m_valid_o = out_busy_q;
    assign m_real_o  = bin_re_q[out_cnt_q];
    assign m_imag_o  = bin_im_q[out_cnt_q];
    assign m_last_o  = out_busy_q && (out_cnt_q == 2'd3);

    // 4-point butterfly over the sign-extended input buffer
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            x_re[i] = {{2{buf_re_q[i][DATA_WIDTH-1]}}, buf_re_q[i]};
            x_im[i] = {{2{buf_im_q[i][DATA_WIDTH-1]}}, buf_im_q[i]};
        end
        a_re = x_re[0] + x_re[2];
        a_im = x_im[0] + x_im[2];
        b_re = x_re[0] - x_re[2];
        b_im = x_im[0] - x_im[2];
        c_re = x_re[1] + x_re[3];
        c_im = x_im[1] + x_im[3];
        d_re = x_re[1] - x_re[3];
        d_im = x_im[1] - x_im[3];

        f_re[0] = a_re + c_re;
        f_im[0] = a_im + c_im;
        f_re[2] = a_re - c_re;
        f_im[2] = a_im - c_im;
        // j*d = (-d_im, d_re); forward uses b - j*d for bin 1, inverse swaps bins 1 and 3
        if (!frame_inv_q) begin
            f_re[1] = b_re + d_im;
            f_im[1] = b_im - d_re;
            f_re[3] = b_re - d_im;
            f_im[3] = b_im + d_re;
        end else begin
            f_re[1] = b_re - d_im;
            f_im[1] = b_im + d_re;
            f_re[3] = b_re + d_im;
            f_im[3] = b_im - d_re;
        end
    end

    // Next-state logic
    always_comb begin
        in_cnt_d    = in_cnt_q;
        full_in_d   = full_in_q;
        frame_inv_d = frame_inv_q;
        out_busy_d  = out_busy_q;
        out_cnt_d   = out_cnt_q;
        for (int i = 0; i < 4; i++) begin
            buf_re_d[i] = buf_re_q[i];
            buf_im_d[i] = buf_im_q[i];
            bin_re_d[i] = bin_re_q[i];
            bin_im_d[i] = bin_im_q[i];
        end

        if (in_fire) begin
            buf_re_d[in_cnt_q] = s_real_i;
            buf_im_d[in_cnt_q] = s_imag_i;
            if (in_cnt_q == 2'd0) begin
                frame_inv_d = s_inv_i;
            end
            if (in_cnt_q == 2'd3) begin
                full_in_d = 1'b1;
            end
            in_cnt_d = in_cnt_q + 2'd1;
        end

        if (out_fire) begin
            out_cnt_d = out_cnt_q + 2'd1;
            if (out_cnt_q == 2'd3) begin
                out_busy_d = 1'b0;
            end
        end

        // Transfer overrides the drain bookkeeping when both happen on the same edge.
        if (xfer) begin
            for (int k = 0; k < 4; k++) begin
                bin_re_d[k] = (SCALE != 0) ? (f_re[k] >>> 2) : f_re[k];
                bin_im_d[k] = (SCALE != 0) ? (f_im[k] >>> 2) : f_im[k];
            end
            out_busy_d = 1'b1;
            out_cnt_d  = 2'd0;
            full_in_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_cnt_q    <= 2'd0;
            full_in_q   <= 1'b0;
            frame_inv_q <= 1'b0;
            out_busy_q  <= 1'b0;
            out_cnt_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                buf_re_q[i] <= '0;
                buf_im_q[i] <= '0;
                bin_re_q[i] <= '0;
                bin_im_q[i] <= '0;
            end
        end else begin
            in_cnt_q    <= in_cnt_d;
            full_in_q   <= full_in_d;
            frame_inv_q <= frame_inv_d;
            out_busy_q  <= out_busy_d;
            out_cnt_q   <= out_cnt_d;
            for (int i = 0; i < 4; i++) begin
                buf_re_q[i] <= buf_re_d[i];
                buf_im_q[i] <= buf_im_d[i];
                bin_re_q[i] <= bin_re_d[i];
                bin_im_q[i] <= bin_im_d[i];
            end
        end
    end

endmodule
